// File: rtl/deser_fifo_pkg.sv
// Shared types and defaults for the serial-in / serial-out word queue.
package deser_fifo_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/deser_fifo_if.sv
// Serial bit-in, serial word-out bus of deser_fifo; the producer/consumer side is master.
interface deser_fifo_if
    import deser_fifo_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) ();

    localparam int CW = cnt_width(DEPTH);

    logic          data_in;
    logic          write_in;
    logic          dequeue_in;
    logic          data_out;
    logic          valid_out;
    logic          status_out;
    logic          empty_out;
    logic [CW-1:0] count_out;
    logic          overflow_out;

    modport master (
        output data_in, write_in, dequeue_in,
        input  data_out, valid_out, status_out, empty_out, count_out, overflow_out
    );

    modport slave (
        input  data_in, write_in, dequeue_in,
        output data_out, valid_out, status_out, empty_out, count_out, overflow_out
    );

endinterface

// File: rtl/fifo_ring.sv
// Circular word queue with registered count/full/empty; rdata shows the head word combinationally.
// A push on full is accepted only when a pop happens in the same cycle.
module fifo_ring #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             r_full;
    logic             r_empty;

    logic             w_do_pop;
    logic             w_do_push;
    logic [CW-1:0]    w_count_nxt;

    assign w_do_pop  = pop & ~r_empty;
    assign w_do_push = push & (~r_full | w_do_pop);

    always_comb begin
        w_count_nxt = r_count;
        case ({w_do_push, w_do_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + AW'(1);
            if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == DEPTH_C);
            r_empty <= (w_count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= wdata;
    end

    assign rdata = r_mem[r_rptr];
    assign count = r_count;
    assign full  = r_full;
    assign empty = r_empty;

endmodule

// File: rtl/deser_fifo.sv
// Deserialises strobed bits into words, queues them, and replays a word serially per dequeue edge.
// Strobes take one cycle to detect; a word is queued one cycle after its last bit; full queue drops and flags overflow.
module deser_fifo
    import deser_fifo_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic  clock1M,
    input  logic  reset,
    deser_fifo_if.slave bus
);

    localparam int CW = cnt_width(DEPTH);
    localparam int BW = $clog2(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    logic             r_din_s;
    logic             r_wr_s;
    logic             r_wr_d;
    logic             r_deq_s;
    logic             r_deq_d;
    logic             w_wr_edge;
    logic             w_deq_edge;

    logic [WIDTH-1:0] r_asm;
    logic [BW-1:0]    r_bit_cnt;
    logic             r_push;
    logic [WIDTH-1:0] w_asm_nxt;

    logic [WIDTH-1:0] w_rdata;
    logic [CW-1:0]    w_count;
    logic             w_full;
    logic             w_empty;
    logic             r_overflow;

    ser_state_t       r_state;
    ser_state_t       w_state_nxt;
    logic [WIDTH-1:0] r_osr;
    logic [BW-1:0]    r_obit_cnt;
    logic             w_pop;
    logic             w_valid;
    logic             w_dout;

    always_ff @(posedge clock1M or negedge reset) begin
        if (!reset) begin
            r_din_s <= 1'b0;
            r_wr_s  <= 1'b0;
            r_wr_d  <= 1'b0;
            r_deq_s <= 1'b0;
            r_deq_d <= 1'b0;
        end else begin
            r_din_s <= bus.data_in;
            r_wr_s  <= bus.write_in;
            r_wr_d  <= r_wr_s;
            r_deq_s <= bus.dequeue_in;
            r_deq_d <= r_deq_s;
        end
    end

    assign w_wr_edge  = r_wr_s & ~r_wr_d;
    assign w_deq_edge = r_deq_s & ~r_deq_d;

    assign w_asm_nxt = MSB_FIRST ? {r_asm[WIDTH-2:0], r_din_s}
                                 : {r_din_s, r_asm[WIDTH-1:1]};

    // Strobe edges are at least two cycles apart, so r_asm is stable in the push cycle.
    always_ff @(posedge clock1M or negedge reset) begin
        if (!reset) begin
            r_asm     <= '0;
            r_bit_cnt <= '0;
            r_push    <= 1'b0;
        end else begin
            r_push <= 1'b0;
            if (w_wr_edge) begin
                r_asm <= w_asm_nxt;
                if (r_bit_cnt == LAST_BIT) begin
                    r_bit_cnt <= '0;
                    r_push    <= 1'b1;
                end else begin
                    r_bit_cnt <= r_bit_cnt + BW'(1);
                end
            end
        end
    end

    fifo_ring #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ring (
        .clk   (clock1M),
        .rst_n (reset),
        .push  (r_push),
        .pop   (w_pop),
        .wdata (r_asm),
        .rdata (w_rdata),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clock1M or negedge reset) begin
        if (!reset) begin
            r_overflow <= 1'b0;
        end else if (r_push && w_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clock1M or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:  if (w_deq_edge && !w_empty)   w_state_nxt = SHIFT;
            SHIFT: if (r_obit_cnt == LAST_BIT)   w_state_nxt = IDLE;
            default:                             w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_pop   = 1'b0;
        w_valid = 1'b0;
        w_dout  = 1'b0;
        case (r_state)
            IDLE: w_pop = w_deq_edge & ~w_empty;
            SHIFT: begin
                w_valid = 1'b1;
                w_dout  = MSB_FIRST ? r_osr[WIDTH-1] : r_osr[0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock1M or negedge reset) begin
        if (!reset) begin
            r_osr      <= '0;
            r_obit_cnt <= '0;
        end else if (w_pop) begin
            r_osr      <= w_rdata;
            r_obit_cnt <= '0;
        end else if (r_state == SHIFT) begin
            r_osr      <= MSB_FIRST ? (r_osr << 1) : (r_osr >> 1);
            r_obit_cnt <= (r_obit_cnt == LAST_BIT) ? '0 : r_obit_cnt + BW'(1);
        end
    end

    assign bus.data_out     = w_dout;
    assign bus.valid_out    = w_valid;
    assign bus.status_out   = w_full;
    assign bus.empty_out    = w_empty;
    assign bus.count_out    = w_count;
    assign bus.overflow_out = r_overflow;

endmodule

// File: tb/tb_deser_fifo.sv
// Directed bench: three deser_fifo instances (defaults, LSB-first, DEPTH=4) driven by bit-level tasks.
module tb_deser_fifo;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [2:0] t_din = '0;
    logic [2:0] t_wr  = '0;
    logic [2:0] t_deq = '0;
    wire  [2:0] t_dout, t_val, t_full, t_empty, t_ovf;
    wire  [2:0][7:0] t_cnt;

    deser_fifo_if #(.DEPTH(8)) if0 ();
    deser_fifo_if #(.DEPTH(8)) if1 ();
    deser_fifo_if #(.DEPTH(4)) if2 ();

    assign if0.data_in = t_din[0]; assign if0.write_in = t_wr[0]; assign if0.dequeue_in = t_deq[0];
    assign if1.data_in = t_din[1]; assign if1.write_in = t_wr[1]; assign if1.dequeue_in = t_deq[1];
    assign if2.data_in = t_din[2]; assign if2.write_in = t_wr[2]; assign if2.dequeue_in = t_deq[2];

    assign t_dout  = {if2.data_out,     if1.data_out,     if0.data_out};
    assign t_val   = {if2.valid_out,    if1.valid_out,    if0.valid_out};
    assign t_full  = {if2.status_out,   if1.status_out,   if0.status_out};
    assign t_empty = {if2.empty_out,    if1.empty_out,    if0.empty_out};
    assign t_ovf   = {if2.overflow_out, if1.overflow_out, if0.overflow_out};
    assign t_cnt[0] = 8'(if0.count_out);
    assign t_cnt[1] = 8'(if1.count_out);
    assign t_cnt[2] = 8'(if2.count_out);

    deser_fifo #(.WIDTH(8), .DEPTH(8), .MSB_FIRST(1'b1)) u_dut0 (.clock1M(clk), .reset(rst_n), .bus(if0.slave));
    deser_fifo #(.WIDTH(8), .DEPTH(8), .MSB_FIRST(1'b0)) u_dut1 (.clock1M(clk), .reset(rst_n), .bus(if1.slave));
    deser_fifo #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b1)) u_dut2 (.clock1M(clk), .reset(rst_n), .bus(if2.slave));

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic send_bit(input int s, input logic b);
        @(negedge clk);
        t_din[s] = b;
        t_wr[s]  = 1'b1;
        repeat (10) @(negedge clk);
        t_wr[s]  = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_word(input int s, input logic [7:0] w, input bit msb);
        for (int i = 0; i < 8; i++) send_bit(s, msb ? w[7-i] : w[i]);
    endtask

    // Records data_out bits in arrival order: first bit lands in bit 7 of an 8-bit result.
    task automatic pop_word(input int s, input bit reedge, output logic [31:0] seq, output int vc);
        seq = '0;
        vc  = 0;
        @(negedge clk);
        t_deq[s] = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (t_val[s]) begin
                seq = {seq[30:0], t_dout[s]};
                vc++;
            end
            if (reedge && c == 3) t_deq[s] = 1'b0;
            if (reedge && c == 4) t_deq[s] = 1'b1;
        end
        t_deq[s] = 1'b0;
        @(negedge clk);
    endtask

    task automatic watch_valid(input int s, input int n, output int hits);
        hits = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (t_val[s]) hits++;
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] seq;
        int vc;
        int hits;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_count",    t_cnt[0],   0);
        check_eq("rst_empty",    t_empty[0], 1);
        check_eq("rst_full",     t_full[0],  0);
        check_eq("rst_overflow", t_ovf[0],   0);
        check_eq("rst_valid",    t_val[0],   0);
        check_eq("rst_dout",     t_dout[0],  0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Two words MSB-first, then replay
        send_word(0, 8'hA5, 1'b1);
        send_word(0, 8'h3C, 1'b1);
        check_eq("t1_count", t_cnt[0],   2);
        check_eq("t1_empty", t_empty[0], 0);
        check_eq("t1_dout_idle", t_dout[0], 0);
        pop_word(0, 1'b0, seq, vc);
        check_eq("t1_word0", seq, 32'hA5);
        check_eq("t1_vcnt0", vc,  8);
        pop_word(0, 1'b0, seq, vc);
        check_eq("t1_word1", seq, 32'h3C);
        check_eq("t1_vcnt1", vc,  8);
        check_eq("t1_empty_after", t_empty[0], 1);
        check_eq("t1_count_after", t_cnt[0],   0);

        // LSB-first instance: 0x01 must come out as 1,0,0,0,0,0,0,0
        send_word(1, 8'h01, 1'b0);
        check_eq("t2_count", t_cnt[1], 1);
        pop_word(1, 1'b0, seq, vc);
        check_eq("t2_seq",  seq, 32'h80);
        check_eq("t2_vcnt", vc,  8);

        // DEPTH=4 overflow
        send_word(2, 8'h11, 1'b1);
        send_word(2, 8'h22, 1'b1);
        send_word(2, 8'h33, 1'b1);
        check_eq("t3_full_at3", t_full[2], 0);
        send_word(2, 8'h44, 1'b1);
        check_eq("t3_full_at4",  t_full[2], 1);
        check_eq("t3_count_at4", t_cnt[2],  4);
        check_eq("t3_ovf_at4",   t_ovf[2],  0);
        send_word(2, 8'h55, 1'b1);
        check_eq("t3_ovf_at5",   t_ovf[2],  1);
        check_eq("t3_count_at5", t_cnt[2],  4);
        check_eq("t3_full_at5",  t_full[2], 1);
        pop_word(2, 1'b0, seq, vc); check_eq("t3_pop0", seq, 32'h11);
        pop_word(2, 1'b0, seq, vc); check_eq("t3_pop1", seq, 32'h22);
        pop_word(2, 1'b0, seq, vc); check_eq("t3_pop2", seq, 32'h33);
        pop_word(2, 1'b0, seq, vc); check_eq("t3_pop3", seq, 32'h44);
        check_eq("t3_empty", t_empty[2], 1);
        check_eq("t3_ovf_sticky", t_ovf[2], 1);

        // Pointer wrap: fill, pop one, push into the freed slot
        send_word(2, 8'h11, 1'b1);
        send_word(2, 8'h22, 1'b1);
        send_word(2, 8'h33, 1'b1);
        send_word(2, 8'h44, 1'b1);
        pop_word(2, 1'b0, seq, vc); check_eq("t4_pop_first", seq, 32'h11);
        check_eq("t4_count_3", t_cnt[2], 3);
        send_word(2, 8'h66, 1'b1);
        check_eq("t4_full_again", t_full[2], 1);
        pop_word(2, 1'b0, seq, vc); check_eq("t4_pop0", seq, 32'h22);
        pop_word(2, 1'b0, seq, vc); check_eq("t4_pop1", seq, 32'h33);
        pop_word(2, 1'b0, seq, vc); check_eq("t4_pop2", seq, 32'h44);
        pop_word(2, 1'b0, seq, vc); check_eq("t4_pop3", seq, 32'h66);
        check_eq("t4_empty", t_empty[2], 1);
        check_eq("t4_count", t_cnt[2],   0);

        // Dequeue on empty queue
        @(negedge clk);
        t_deq[0] = 1'b1;
        watch_valid(0, 15, hits);
        t_deq[0] = 1'b0;
        check_eq("t5_empty_deq_valid", hits, 0);
        check_eq("t5_empty_deq_count", t_cnt[0], 0);

        // Second dequeue edge during SHIFT must not be remembered
        send_word(0, 8'h5A, 1'b1);
        send_word(0, 8'h96, 1'b1);
        check_eq("t6_count2", t_cnt[0], 2);
        pop_word(0, 1'b1, seq, vc);
        check_eq("t6_word", seq, 32'h5A);
        check_eq("t6_vcnt", vc,  8);
        check_eq("t6_count1", t_cnt[0], 1);
        watch_valid(0, 15, hits);
        check_eq("t6_no_extra_pop", hits, 0);
        check_eq("t6_count_kept", t_cnt[0], 1);

        // Reset in the middle of an output word
        @(negedge clk);
        t_deq[0] = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("t7_in_shift", t_val[0], 1);
        rst_n = 1'b0;
        t_deq[0] = 1'b0;
        @(negedge clk);
        check_eq("t7_rst_valid", t_val[0],  0);
        check_eq("t7_rst_dout",  t_dout[0], 0);
        check_eq("t7_rst_count", t_cnt[0],  0);
        rst_n = 1'b1;
        watch_valid(0, 15, hits);
        check_eq("t7_no_partial_out", hits, 0);

        // Reset after three bits of a word, then a full word
        send_bit(0, 1'b1);
        send_bit(0, 1'b0);
        send_bit(0, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_word(0, 8'hC3, 1'b1);
        check_eq("t8_count", t_cnt[0], 1);
        pop_word(0, 1'b0, seq, vc);
        check_eq("t8_word", seq, 32'hC3);
        check_eq("t8_vcnt", vc,  8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
